// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, flit-type encoding and the output-arbiter FSM states.
package noc_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    FLIT_BODY     = 2'b00,
    FLIT_TAIL     = 2'b01,
    FLIT_HEAD     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  function automatic flit_type_e flit_type(input logic [DATA_W-1:0] flit);
    return flit_type_e'(flit[DATA_W-1 -: 2]);
  endfunction

  function automatic logic opens_pkt(input flit_type_e t);
    return (t == FLIT_HEAD) || (t == FLIT_HEADTAIL);
  endfunction

  function automatic logic closes_pkt(input flit_type_e t);
    return (t == FLIT_TAIL) || (t == FLIT_HEADTAIL);
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first set request after last_ptr, wrapping modulo N.
module rr_arb #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [IDX_W-1:0] idx;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int off = 1; off <= N; off++) begin
      idx = IDX_W'((int'(last_ptr) + off) % N);
      if (!gnt_vld && req[idx]) begin
        gnt_vld  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/output_arb.sv
// Output-port arbiter: grants one input FIFO a whole packet at a time and streams its
// flits to the downstream FIFO without local storage.
module output_arb
  import noc_pkg::*;
#(
  parameter int N_IN  = 5,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN-1:0]        req_empty,
  input  logic [N_IN*DATA_W-1:0] req_data,
  output logic [N_IN-1:0]        req_rd_en,
  input  logic                   dn_ordy,
  input  logic                   dn_full,
  output logic                   dn_wr_en,
  output logic [DATA_W-1:0]      dn_data,
  output logic [N_IN-1:0]        grant,
  output logic                   busy,
  output logic                   err,
  output logic [CNT_W-1:0]       pkt_cnt
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [N_IN-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
  logic             first_q, first_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [N_IN-1:0]   eligible;
  logic [N_IN-1:0]   bad_head;
  logic [N_IN-1:0]   arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_vld;
  logic [DATA_W-1:0] head_flit;
  logic [DATA_W-1:0] owner_flit;
  flit_type_e        owner_type;
  logic              xfer_go;

  // An input whose head is mid-packet cannot start a packet; it is flagged and left untouched.
  always_comb begin
    eligible  = '0;
    bad_head  = '0;
    head_flit = '0;
    for (int i = 0; i < N_IN; i++) begin
      head_flit = req_data[i*DATA_W +: DATA_W];
      if (!req_empty[i]) begin
        eligible[i] = opens_pkt(flit_type(head_flit));
        bad_head[i] = !opens_pkt(flit_type(head_flit));
      end
    end
  end

  rr_arb #(
    .N     (N_IN),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .req      (eligible),
    .last_ptr (last_ptr_q),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx),
    .gnt_vld  (arb_vld)
  );

  // The data path is a mux from the owner's FIFO head straight to the downstream FIFO.
  always_comb begin
    owner_flit = req_data[owner_q*DATA_W +: DATA_W];
    owner_type = flit_type(owner_flit);
    xfer_go    = (state_q == ST_XFER) && !req_empty[owner_q] && !dn_full;
    req_rd_en  = '0;
    if (xfer_go) req_rd_en[owner_q] = 1'b1;
    dn_wr_en   = xfer_go;
    dn_data    = xfer_go ? owner_flit : '0;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    last_ptr_d = last_ptr_q;
    first_d    = first_q;
    err_d      = err_q;
    pkt_cnt_d  = pkt_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|bad_head) err_d = 1'b1;
        if (dn_ordy && arb_vld) begin
          state_d = ST_XFER;
          owner_d = arb_idx;
          grant_d = arb_gnt;
          first_d = 1'b1;
        end
      end
      ST_XFER: begin
        if (xfer_go) begin
          first_d = 1'b0;
          if (!first_q && opens_pkt(owner_type)) err_d = 1'b1;
          // A closing flit ends the packet even when it arrived as a stray HEADTAIL.
          if (closes_pkt(owner_type)) begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            last_ptr_d = owner_q;
            pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      grant_q    <= '0;
      last_ptr_q <= IDX_W'(N_IN - 1);
      first_q    <= 1'b0;
      err_q      <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
      first_q    <= first_d;
      err_q      <= err_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q == ST_XFER);
  assign err     = err_q;
  assign pkt_cnt = pkt_cnt_q;

endmodule
